pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage 8-bit pipeline (IF, ID, EX, MEM, WB). It generates the stall and flush controls for the IF/ID and ID/EX pipeline registers and the EX-stage operand forwarding selects. It sequences multi-cycle MUL occupancy of EX with a small FSM and counts stall cycles for performance monitoring. It sits beside the pipeline registers and takes stage opcode and register IDs from them.

Parameters:
MUL_LAT, 4, cycles a MUL occupies EX; legal range >= 2.
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  in  1  clock
rstn  in  1  reset
id_valid  in  1  ID stage holds a real instruction
id_opcode  in  4  opcode in ID
id_rs  in  3  ID source register A
id_rt  in  3  ID source register B
ex_opcode  in  4  opcode in EX (ID/EX register output)
ex_rs  in  3  EX source A
ex_rt  in  3  EX source B
ex_rd  in  3  EX destination
mem_we  in  1  EX/MEM writes the register file
mem_rd  in  3  EX/MEM destination
wb_we  in  1  MEM/WB writes the register file
wb_rd  in  3  MEM/WB destination
branch_taken  in  1  branch resolved taken in EX this cycle
stall_if  out  1  hold PC and IF/ID
stall_id  out  1  hold IF/ID contents
stall_ex  out  1  hold ID/EX contents
flush_if_id  out  1  zero IF/ID next edge
flush_id_ex  out  1  zero ID/EX next edge (bubble)
fwd_a  out  2  operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b  out  2  operand B select, same encoding
mul_busy  out  1  FSM in S_MUL
stall_cnt  out  CNT_W  saturating count of cycles with stall_if=1

Behaviour:
- Reset: clk and rstn as already decided, i.e. reset rstn, asynchronous, active-low; clock clk. While rstn=0: FSM=S_RUN, mul counter=0, stall_cnt=0, every output 0. Combinational outputs are gated by rstn.
- Register 0 is the null destination. rd=0 never forwards and never causes a hazard.
- Forwarding (combinational):
  - fwd_a=01 if mem_we && mem_rd!=0 && mem_rd==ex_rs.
  - Else fwd_a=10 if wb_we && wb_rd!=0 && wb_rd==ex_rs.
  - Else fwd_a=00.
  - fwd_b is the same rule using ex_rt. EX/MEM has priority over MEM/WB.
- Operand use, decoded from the package:
  - uses_rs: every opcode except NOP and JMP.
  - uses_rt: ADD/SUB/AND/OR/XOR/STORE/MUL/BEQ.
- Load-use hazard: ex_opcode==OP_LOAD && ex_rd!=0 && id_valid && ((uses_rs && ex_rd==id_rs) || (uses_rt && ex_rd==id_rt)).
  - Response: stall_if=stall_id=1 and flush_id_ex=1 for exactly one cycle.
  - The load advances, so the next cycle the hazard is resolved by MEM/WB forwarding.
- Branch: branch_taken=1 gives flush_if_id=flush_id_ex=1 that cycle and forces all stalls to 0. Branch has the highest priority and suppresses load-use and MUL detection.
- FSM states:
  - S_RUN:
    - If ex_opcode==OP_MUL and no branch: assert stall_if/stall_id/stall_ex, load cnt=MUL_LAT-2, go to S_MUL.
    - Else apply load-use and branch logic.
  - S_MUL:
    - mul_busy=1.
    - If cnt!=0: assert stall_if/stall_id/stall_ex, cnt-=1.
    - If cnt==0: all stalls 0, so EX advances at this edge; go to S_RUN.
    - Load-use and MUL detection are suppressed in S_MUL.
  - Net effect: a MUL occupies EX for exactly MUL_LAT cycles, with stalls in the first MUL_LAT-1 of them.
- Priority: branch > MUL > load-use. A flush and a stall are never asserted on the same register in the same cycle, except load-use (stall IF/ID plus flush ID/EX).
- stall_cnt: increments on each clk edge where stall_if=1; holds at all-ones.
- Reset mid-S_MUL: immediate return to S_RUN with outputs 0; no residual stall after rstn rises.

Decomposition:
- Package pipe_pkg:
  - Opcodes: OP_NOP=4'h0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_ADDI=8, OP_LOAD=A, OP_STORE=B, OP_MUL=C, OP_BEQ=E, OP_JMP=F.
  - Forward-select constants FWD_RF/FWD_EXMEM/FWD_MEMWB.
  - FSM state encoding.
  - uses_rs/uses_rt decode functions.
- Sub-module pipe_fwd_unit: purely combinational forwarding for one operand, instantiated twice (A and B).

Test Plan:
- Reset: rstn=0 mid-run → all outputs 0 asynchronously. After release with ex_opcode=NOP → stall/flush=0, fwd=00, stall_cnt=0.
- Forward priority: ex_rs=3, mem_we=1 mem_rd=3, wb_we=1 wb_rd=3 → fwd_a=01. Then mem_rd=0 → fwd_a=10. Then ex_rs=0 with mem_rd=wb_rd=0 → fwd_a=00.
- Load-use: ex LOAD rd=2, id ADD rs=2 → stall_if=stall_id=flush_id_ex=1 for one cycle, stall_cnt 0→1. Same with id ADDI rt=2 rs=5 → no stall.
- MUL, MUL_LAT=4: MUL enters EX → stall_ex/stall_if=1 for 3 cycles, mul_busy=1 for cycles 2–4, 4th cycle stalls=0, stall_cnt +3.
- Branch vs load-use: branch_taken=1 with a concurrent load-use match → flush_if_id=flush_id_ex=1, stall_if=0, stall_cnt unchanged.
- Reset in S_MUL (second stall cycle) → stalls drop immediately. After release, ex_opcode=ADD → no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, forward
// selects, FSM state encoding and operand-use decode.
package pipe_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_ADDI  = 4'h8;
    localparam logic [3:0] OP_LOAD  = 4'hA;
    localparam logic [3:0] OP_STORE = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hC;
    localparam logic [3:0] OP_BEQ   = 4'hE;
    localparam logic [3:0] OP_JMP   = 4'hF;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MUL = 1'b1
    } state_t;

    function automatic logic uses_rs(input logic [3:0] op);
        return (op != OP_NOP) && (op != OP_JMP);
    endfunction

    function automatic logic uses_rt(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_STORE, OP_MUL, OP_BEQ: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline registers (master) and the hazard
// controller (slave).
interface pipe_hazard_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_opcode;
    logic [2:0]       id_rs;
    logic [2:0]       id_rt;
    logic [3:0]       ex_opcode;
    logic [2:0]       ex_rs;
    logic [2:0]       ex_rt;
    logic [2:0]       ex_rd;
    logic             mem_we;
    logic [2:0]       mem_rd;
    logic             wb_we;
    logic [2:0]       wb_rd;
    logic             branch_taken;
    logic             stall_if;
    logic             stall_id;
    logic             stall_ex;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mul_busy;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt,
        output ex_opcode, ex_rs, ex_rt, ex_rd,
        output mem_we, mem_rd, wb_we, wb_rd, branch_taken,
        input  stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex,
        input  fwd_a, fwd_b, mul_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt,
        input  ex_opcode, ex_rs, ex_rt, ex_rd,
        input  mem_we, mem_rd, wb_we, wb_rd, branch_taken,
        output stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex,
        output fwd_a, fwd_b, mul_busy, stall_cnt
    );
endinterface

// File: rtl/pipe_fwd_unit.sv
// EX-stage forwarding select for one operand; EX/MEM wins over MEM/WB and
// register 0 never forwards.
module pipe_fwd_unit
    import pipe_pkg::*;
(
    input  logic [2:0] i_src,
    input  logic       i_mem_we,
    input  logic [2:0] i_mem_rd,
    input  logic       i_wb_we,
    input  logic [2:0] i_wb_rd,
    output logic [1:0] o_fwd
);

    always_comb begin
        o_fwd = FWD_RF;
        if (i_mem_we && (i_mem_rd != 3'd0) && (i_mem_rd == i_src))
            o_fwd = FWD_EXMEM;
        else if (i_wb_we && (i_wb_rd != 3'd0) && (i_wb_rd == i_src))
            o_fwd = FWD_MEMWB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stall/flush generation,
// operand forwarding, MUL occupancy sequencing and stall-cycle counting.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rstn,
    pipe_hazard_if.slave  bus
);

    localparam int          CW       = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 2);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_mul_start;
    logic              w_mul_hold;
    logic              w_load_use;
    logic              w_stall_fe;
    logic              w_stall_ex;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    pipe_fwd_unit u_fwd_a (
        .i_src    (bus.ex_rs),
        .i_mem_we (bus.mem_we),
        .i_mem_rd (bus.mem_rd),
        .i_wb_we  (bus.wb_we),
        .i_wb_rd  (bus.wb_rd),
        .o_fwd    (w_fwd_a)
    );

    pipe_fwd_unit u_fwd_b (
        .i_src    (bus.ex_rt),
        .i_mem_we (bus.mem_we),
        .i_mem_rd (bus.mem_rd),
        .i_wb_we  (bus.wb_we),
        .i_wb_rd  (bus.wb_rd),
        .o_fwd    (w_fwd_b)
    );

    // Branch beats everything; MUL and load-use are only looked for in S_RUN.
    assign w_mul_start = (r_state == S_RUN) && !bus.branch_taken
                         && (bus.ex_opcode == OP_MUL);
    assign w_mul_hold  = (r_state == S_MUL) && !bus.branch_taken
                         && (r_cnt != '0);
    assign w_load_use  = (r_state == S_RUN) && !bus.branch_taken
                         && (bus.ex_opcode == OP_LOAD) && (bus.ex_rd != 3'd0)
                         && bus.id_valid
                         && ((uses_rs(bus.id_opcode) && (bus.ex_rd == bus.id_rs))
                          || (uses_rt(bus.id_opcode) && (bus.ex_rd == bus.id_rt)));

    assign w_stall_ex = w_mul_start || w_mul_hold;
    assign w_stall_fe = w_stall_ex || w_load_use;

    assign bus.stall_if    = rstn && w_stall_fe;
    assign bus.stall_id    = rstn && w_stall_fe;
    assign bus.stall_ex    = rstn && w_stall_ex;
    assign bus.flush_if_id = rstn && bus.branch_taken;
    assign bus.flush_id_ex = rstn && (bus.branch_taken || w_load_use);
    assign bus.fwd_a       = rstn ? w_fwd_a : FWD_RF;
    assign bus.fwd_b       = rstn ? w_fwd_b : FWD_RF;
    assign bus.mul_busy    = r_busy;
    assign bus.stall_cnt   = r_stall_cnt;

    // The entry cycle is already a stall, so the counter starts at MUL_LAT-2
    // and the final (cnt==0) cycle lets EX advance.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_mul_start) begin
                        r_state <= S_MUL;
                        r_cnt   <= CNT_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_MUL: begin
                    if (bus.branch_taken || (r_cnt == '0)) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_stall_cnt <= '0;
        else if (w_stall_fe && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, forwarding priority, load-use,
// MUL occupancy, branch priority and reset during MUL.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    pipe_hazard_if #(.CNT_W(16)) bus ();

    pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // stall_if, stall_id, stall_ex, flush_if_id, flush_id_ex, mul_busy
    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        chk(tag, {28'd0 - 28'd0 + 26'd0, bus.stall_if, bus.stall_id, bus.stall_ex,
                  bus.flush_if_id, bus.flush_id_ex, bus.mul_busy}, {26'd0, exp});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        bus.id_valid = 1'b0; bus.id_opcode = OP_NOP; bus.id_rs = 3'd0; bus.id_rt = 3'd0;
        bus.ex_opcode = OP_NOP; bus.ex_rs = 3'd0; bus.ex_rt = 3'd0; bus.ex_rd = 3'd0;
        bus.mem_we = 1'b0; bus.mem_rd = 3'd0; bus.wb_we = 1'b0; bus.wb_rd = 3'd0;
        bus.branch_taken = 1'b0;

        repeat (2) @(negedge clk);
        chk_ctl("reset_ctl", 6'b000000);
        chk("reset_cnt", 32'(bus.stall_cnt), 32'd0);

        rstn = 1'b1;
        @(negedge clk); #1;
        chk_ctl("idle_ctl", 6'b000000);
        chk("idle_fwd", {28'd0, bus.fwd_a, bus.fwd_b}, 32'h0);
        chk("idle_cnt", 32'(bus.stall_cnt), 32'd0);

        // forwarding priority
        @(negedge clk);
        bus.ex_opcode = OP_ADD; bus.ex_rs = 3'd3; bus.ex_rt = 3'd5;
        bus.mem_we = 1'b1; bus.mem_rd = 3'd3; bus.wb_we = 1'b1; bus.wb_rd = 3'd3;
        #1;
        chk("fwd_a_exmem", 32'(bus.fwd_a), 32'h1);
        chk("fwd_b_none", 32'(bus.fwd_b), 32'h0);
        bus.mem_rd = 3'd0; #1;
        chk("fwd_a_memwb", 32'(bus.fwd_a), 32'h2);
        bus.wb_rd = 3'd5; bus.mem_rd = 3'd3; bus.mem_we = 1'b0; #1;
        chk("fwd_a_mem_we0", 32'(bus.fwd_a), 32'h0);
        chk("fwd_b_memwb", 32'(bus.fwd_b), 32'h2);
        bus.mem_we = 1'b1; bus.mem_rd = 3'd5; #1;
        chk("fwd_b_exmem", 32'(bus.fwd_b), 32'h1);
        bus.ex_rs = 3'd0; bus.mem_rd = 3'd0; bus.wb_rd = 3'd0; #1;
        chk("fwd_a_r0", 32'(bus.fwd_a), 32'h0);
        chk_ctl("fwd_no_stall", 6'b000000);
        bus.mem_we = 1'b0; bus.wb_we = 1'b0;

        // load-use: LOAD r2 in EX, ADD using r2 in ID
        @(negedge clk);
        bus.ex_opcode = OP_LOAD; bus.ex_rd = 3'd2; bus.ex_rs = 3'd1; bus.ex_rt = 3'd0;
        bus.id_valid = 1'b1; bus.id_opcode = OP_ADD; bus.id_rs = 3'd2; bus.id_rt = 3'd7;
        #1;
        chk_ctl("lu_stall", 6'b110010);
        @(negedge clk);
        chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
        bus.ex_opcode = OP_ADD; bus.ex_rd = 3'd2; #1;
        chk_ctl("lu_resolved", 6'b000000);
        bus.ex_opcode = OP_LOAD; bus.id_opcode = OP_ADDI; bus.id_rs = 3'd5; bus.id_rt = 3'd2; #1;
        chk_ctl("lu_addi_rt", 6'b000000);
        bus.id_opcode = OP_STORE; #1;
        chk_ctl("lu_store_rt", 6'b110010);
        bus.id_valid = 1'b0; #1;
        chk_ctl("lu_id_invalid", 6'b000000);
        bus.id_valid = 1'b1; bus.ex_rd = 3'd0; bus.id_rt = 3'd0; #1;
        chk_ctl("lu_rd0", 6'b000000);
        bus.ex_opcode = OP_NOP; bus.id_opcode = OP_NOP; bus.id_valid = 1'b0;

        // MUL occupies EX for 4 cycles
        @(negedge clk);
        bus.ex_opcode = OP_MUL; bus.ex_rd = 3'd4; #1;
        chk_ctl("mul_c1", 6'b111000);
        @(negedge clk);
        chk_ctl("mul_c2", 6'b111001);
        @(negedge clk);
        chk_ctl("mul_c3", 6'b111001);
        @(negedge clk);
        chk_ctl("mul_c4", 6'b000001);
        @(negedge clk);
        bus.ex_opcode = OP_ADD; #1;
        chk_ctl("mul_done", 6'b000000);
        chk("mul_cnt", 32'(bus.stall_cnt), 32'd4);

        // branch overrides a concurrent load-use
        @(negedge clk);
        bus.ex_opcode = OP_LOAD; bus.ex_rd = 3'd2;
        bus.id_valid = 1'b1; bus.id_opcode = OP_ADD; bus.id_rs = 3'd2;
        bus.branch_taken = 1'b1; #1;
        chk_ctl("br_lu", 6'b000110);
        @(negedge clk);
        bus.branch_taken = 1'b0; bus.ex_opcode = OP_NOP; bus.id_valid = 1'b0; #1;
        chk("br_cnt", 32'(bus.stall_cnt), 32'd4);

        // reset in the second MUL stall cycle
        @(negedge clk);
        bus.ex_opcode = OP_MUL; #1;
        chk_ctl("rmul_c1", 6'b111000);
        @(negedge clk);
        chk_ctl("rmul_c2", 6'b111001);
        chk("rmul_cnt", 32'(bus.stall_cnt), 32'd5);
        rstn = 1'b0; #1;
        chk_ctl("rmul_async", 6'b000000);
        chk("rmul_cnt_clr", 32'(bus.stall_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1; bus.ex_opcode = OP_ADD; #1;
        chk_ctl("rmul_release", 6'b000000);
        @(negedge clk);
        chk_ctl("rmul_after", 6'b000000);
        chk("rmul_cnt_after", 32'(bus.stall_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
